// File: rtl/clk_div_prog.sv
// Programmable clock divider: slow_clk toggles and tick pulses every D = max(cur_div,1) enabled cycles.
// Latency: all outputs registered, one edge. Optional macro CLK_DIV_IMM_LOAD_EN makes div_load take effect at once.
module clk_div_prog #(
    parameter int CNT_W   = 26,
    parameter int DEF_DIV = 50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_load,
    output logic             slow_clk,
    output logic             tick,
    output logic             load_pending,
    output logic [CNT_W-1:0] cur_div
);
    localparam logic [CNT_W-1:0] DEF_VAL = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] eff_div;
    logic             at_term;

    // A zero divisor behaves as divide-by-one so the counter never wraps.
    always_comb begin
        eff_div = (cur_div == '0) ? ONE : cur_div;
        at_term = (cnt == eff_div - ONE);
    end

`ifdef CLK_DIV_IMM_LOAD_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt          <= '0;
            slow_clk     <= 1'b0;
            tick         <= 1'b0;
            load_pending <= 1'b0;
            cur_div      <= DEF_VAL;
        end else if (div_load) begin
            cur_div <= div_in;
            cnt     <= '0;
            tick    <= 1'b0;
        end else if (en && at_term) begin
            cnt      <= '0;
            slow_clk <= ~slow_clk;
            tick     <= 1'b1;
        end else if (en) begin
            cnt  <= cnt + ONE;
            tick <= 1'b0;
        end else begin
            tick <= 1'b0;
        end
    end
`else
    logic [CNT_W-1:0] shadow;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt          <= '0;
            slow_clk     <= 1'b0;
            tick         <= 1'b0;
            load_pending <= 1'b0;
            shadow       <= DEF_VAL;
            cur_div      <= DEF_VAL;
        end else begin
            if (en && at_term) begin
                cnt      <= '0;
                slow_clk <= ~slow_clk;
                tick     <= 1'b1;
            end else if (en) begin
                cnt  <= cnt + ONE;
                tick <= 1'b0;
            end else begin
                tick <= 1'b0;
            end
            // A fresh capture wins over applying the old shadow on the same edge.
            if (div_load) begin
                shadow       <= div_in;
                load_pending <= 1'b1;
            end else if (en && at_term && load_pending) begin
                cur_div      <= shadow;
                load_pending <= 1'b0;
            end
        end
    end
`endif
endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog (DEF_DIV=4); expected outputs queued per edge, compared by a monitor.
module tb_clk_div_prog;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [7:0] div_in = '0;
    logic       div_load = 1'b0;
    logic       slow_clk;
    logic       tick;
    logic       load_pending;
    logic [7:0] cur_div;

    typedef struct {
        logic  tick;
        logic  slow;
        logic  pend;
        int    div;
        string name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    clk_div_prog #(.CNT_W(8), .DEF_DIV(4)) dut (
        .clk(clk), .rst(rst), .en(en), .div_in(div_in), .div_load(div_load),
        .slow_clk(slow_clk), .tick(tick), .load_pending(load_pending), .cur_div(cur_div)
    );

    always #5 clk = ~clk;

    // Drive one edge's inputs and queue the outputs expected just after that edge.
    task automatic step(input logic r, input logic e, input logic l, input int d,
                        input logic xt, input logic xs, input logic xp, input int xd,
                        input string nm);
        exp_t x;
        @(negedge clk);
        rst      = r;
        en       = e;
        div_load = l;
        div_in   = d[7:0];
        x.tick = xt; x.slow = xs; x.pend = xp; x.div = xd; x.name = nm;
        sb.push_back(x);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                checks++;
                if (tick !== x.tick || slow_clk !== x.slow || load_pending !== x.pend
                    || int'(cur_div) != x.div || $isunknown(cur_div)) begin
                    errors++;
                    $display("FAIL %s: got tick=%b slow=%b pend=%b div=%0d, want tick=%b slow=%b pend=%b div=%0d",
                             x.name, tick, slow_clk, load_pending, cur_div,
                             x.tick, x.slow, x.pend, x.div);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        // Reset held for two edges.
        step(0, 1, 1, 9, 0, 0, 0, 4, "reset0");
        step(0, 1, 0, 0, 0, 0, 0, 4, "reset1");
        // Default divisor 4: ticks on enabled edges 4, 8, 12.
        for (int e = 1; e <= 12; e++)
            step(1, 1, 0, 0, (e % 4) == 0, ((e / 4) % 2) == 1, 0, 4, "def_period");
`ifdef CLK_DIV_IMM_LOAD_EN
        step(1, 1, 0, 0, 0, 1, 0, 4, "imm_cnt1");
        step(1, 1, 0, 0, 0, 1, 0, 4, "imm_cnt2");
        step(1, 1, 1, 3, 0, 1, 0, 3, "imm_load");
        for (int k = 1; k <= 3; k++)
            step(1, 1, 0, 0, k == 3, k != 3, 0, 3, "imm_period");
`else
        // Load 6 at counter=1; old period finishes first.
        step(1, 1, 0, 0, 0, 1, 0, 4, "pre_load");
        step(1, 1, 1, 6, 0, 1, 1, 4, "load6");
        step(1, 1, 0, 0, 0, 1, 1, 4, "load6_wait");
        step(1, 1, 0, 0, 1, 0, 0, 6, "load6_apply");
        for (int k = 1; k <= 12; k++)
            step(1, 1, 0, 0, (k % 6) == 0, ((k / 6) % 2) == 1, 0, 6, "div6_period");
        // Freeze at counter=2 for 5 cycles, then resume.
        step(1, 1, 0, 0, 0, 0, 0, 6, "to_cnt1");
        step(1, 1, 0, 0, 0, 0, 0, 6, "to_cnt2");
        for (int k = 0; k < 5; k++)
            step(1, 0, 0, 0, 0, 0, 0, 6, "en_low_hold");
        for (int r = 1; r <= 4; r++)
            step(1, 1, 0, 0, r == 4, r == 4, 0, 6, "resume_from2");
        // Divisor 0 behaves as 1.
        step(1, 1, 1, 0, 0, 1, 1, 6, "load0");
        for (int k = 0; k < 4; k++)
            step(1, 1, 0, 0, 0, 1, 1, 6, "load0_wait");
        step(1, 1, 0, 0, 1, 0, 0, 0, "load0_apply");
        for (int k = 1; k <= 4; k++)
            step(1, 1, 0, 0, 1, (k % 2) == 1, 0, 0, "div0_every");
        // Load coinciding with a terminal edge is only captured.
        step(1, 1, 1, 3, 1, 1, 1, 0, "load_at_term");
        step(1, 1, 0, 0, 1, 0, 0, 3, "load3_apply");
        step(1, 1, 1, 5, 0, 0, 1, 3, "load5_pending");
        // Reset mid-period discards the pending load.
        step(0, 1, 0, 0, 0, 0, 0, 4, "mid_reset");
        for (int e = 1; e <= 4; e++)
            step(1, 1, 0, 0, e == 4, e == 4, 0, 4, "after_reset");
        // Back-to-back loads: last write wins.
        step(1, 1, 1, 2, 0, 1, 1, 4, "lww_load2");
        step(1, 1, 1, 3, 0, 1, 1, 4, "lww_load3");
        step(1, 1, 0, 0, 0, 1, 1, 4, "lww_wait");
        step(1, 1, 0, 0, 1, 0, 0, 3, "lww_apply");
        for (int k = 1; k <= 3; k++)
            step(1, 1, 0, 0, k == 3, k == 3, 0, 3, "div3_period");
        // Pending load survives en=0 and applies at the next terminal.
        step(1, 1, 1, 2, 0, 1, 1, 3, "pend_load2");
        for (int k = 0; k < 3; k++)
            step(1, 0, 0, 0, 0, 1, 1, 3, "pend_en_low");
        step(1, 1, 0, 0, 0, 1, 1, 3, "pend_resume");
        step(1, 1, 0, 0, 1, 0, 0, 2, "pend_apply");
        step(1, 1, 0, 0, 0, 0, 0, 2, "div2_cnt1");
        step(1, 1, 0, 0, 1, 1, 0, 2, "div2_tick");
`endif
        @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 10 && sb.size() > 0; i++)
            @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left unchecked, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
